// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the seven-segment scan decoder: anode strobe
// codes, active-low segment glyphs and the BCD digit type.
package seg_scan_pkg;

    typedef logic [3:0] bcd_t;

    localparam int NUM_DIGITS = 4;

    localparam logic [3:0] AN_DIG0  = 4'b0111;
    localparam logic [3:0] AN_DIG1  = 4'b1011;
    localparam logic [3:0] AN_DIG2  = 4'b1101;
    localparam logic [3:0] AN_DIG3  = 4'b1110;
    localparam logic [3:0] AN_BLANK = 4'b1111;

    // Full-byte glyphs, dp (bit 7) off; D8 is the four-segment 7 used by the driver.
    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hD8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Bundle of the observed display bus (AN/seg) and the decoded frame status.
// master = the side that drives the display lines; slave = the decoder.
interface seg_scan_decoder_if;
    import seg_scan_pkg::*;

    logic [3:0] AN;
    logic [7:0] seg;
    bcd_t       digit0;
    bcd_t       digit1;
    bcd_t       digit2;
    bcd_t       digit3;
    logic       frame_done;
    logic [3:0] seg_err;
    logic       sync_err;
    logic       locked;
    logic [3:0] blank_mask;

    modport master (
        output AN, seg,
        input  digit0, digit1, digit2, digit3,
        input  frame_done, seg_err, sync_err, locked, blank_mask
    );

    modport slave (
        input  AN, seg,
        output digit0, digit1, digit2, digit3,
        output frame_done, seg_err, sync_err, locked, blank_mask
    );

endinterface

// File: rtl/seg_pattern_decode.sv
// Combinational lookup of an active-low segment byte to a BCD digit.
// The match is on all eight bits, so a lit decimal point makes the byte invalid.
module seg_pattern_decode
    import seg_scan_pkg::*;
(
    input  logic [7:0] seg,
    output logic       valid,
    output bcd_t       bcd
);

    always_comb begin
        valid = 1'b1;
        bcd   = 4'd0;
        case (seg)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Reassembles a multiplexed four-digit seven-segment scan into stable digits.
// Define BLINK_DETECT_EN to build the per-slot blank tracking behind blank_mask.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter bit INPUT_REG = 1'b1
)
(
    input  logic              clk,
    input  logic              rst,
    seg_scan_decoder_if.slave bus
);

    logic [3:0] an_s;
    logic [7:0] seg_s;

    generate
        if (INPUT_REG) begin : g_in_reg
            logic [3:0] an_reg;
            logic [7:0] seg_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    an_reg  <= AN_BLANK;
                    seg_reg <= 8'hFF;
                end else begin
                    an_reg  <= bus.AN;
                    seg_reg <= bus.seg;
                end
            end
            assign an_s  = an_reg;
            assign seg_s = seg_reg;
        end else begin : g_in_direct
            assign an_s  = bus.AN;
            assign seg_s = bus.seg;
        end
    endgenerate

    logic dec_valid;
    bcd_t dec_bcd;

    seg_pattern_decode u_decode (
        .seg   (seg_s),
        .valid (dec_valid),
        .bcd   (dec_bcd)
    );

    logic       one_hot;
    logic       is_blank;
    logic [1:0] strobe_idx;

    always_comb begin
        one_hot    = 1'b1;
        strobe_idx = 2'd0;
        is_blank   = (an_s == AN_BLANK);
        case (an_s)
            AN_DIG0: strobe_idx = 2'd0;
            AN_DIG1: strobe_idx = 2'd1;
            AN_DIG2: strobe_idx = 2'd2;
            AN_DIG3: strobe_idx = 2'd3;
            default: one_hot = 1'b0;
        endcase
    end

    logic [1:0] phase_reg, phase_next;
    logic       locked_reg, locked_next;
    logic       sync_err_reg, sync_next;
    logic       commit_reg, commit_next;
    logic       frame_done_reg;
    logic [1:0] slot;
    logic       write_strobe;
    logic       write_blank;

    // A real strobe names its own slot; blank and multi-hot cycles fall on the phase slot.
    always_comb begin
        slot         = one_hot ? strobe_idx : phase_reg;
        phase_next   = phase_reg;
        locked_next  = locked_reg;
        sync_next    = 1'b0;
        commit_next  = 1'b0;
        write_strobe = 1'b0;
        write_blank  = 1'b0;
        if (!locked_reg) begin
            if (one_hot && strobe_idx == 2'd0) begin
                locked_next  = 1'b1;
                phase_next   = 2'd1;
                write_strobe = 1'b1;
            end
        end else begin
            commit_next = (slot == 2'd3);
            if (one_hot) begin
                write_strobe = 1'b1;
                sync_next    = (strobe_idx != phase_reg);
                phase_next   = strobe_idx + 2'd1;
            end else if (is_blank) begin
                write_blank = 1'b1;
                phase_next  = phase_reg + 2'd1;
            end else begin
                sync_next  = 1'b1;
                phase_next = phase_reg + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_reg      <= 2'd0;
            locked_reg     <= 1'b0;
            sync_err_reg   <= 1'b0;
            commit_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            phase_reg      <= phase_next;
            locked_reg     <= locked_next;
            sync_err_reg   <= sync_next;
            commit_reg     <= commit_next;
            frame_done_reg <= commit_reg;
        end
    end

    bcd_t       out_digit [NUM_DIGITS];
    logic [3:0] seg_err_vec;
    logic [3:0] blank_vec;

    // Commit runs one edge after the slot-3 write, so it copies the completed shadow.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            logic slot_hit;
            bcd_t shadow_digit_reg;
            bcd_t out_digit_reg;
            logic shadow_err_reg;
            logic out_err_reg;

            assign slot_hit = (slot == 2'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shadow_digit_reg <= 4'd0;
                    shadow_err_reg   <= 1'b0;
                    out_digit_reg    <= 4'd0;
                    out_err_reg      <= 1'b0;
                end else begin
                    if (write_strobe && slot_hit) begin
                        if (dec_valid) begin
                            shadow_digit_reg <= dec_bcd;
                            shadow_err_reg   <= 1'b0;
                        end else begin
                            shadow_err_reg   <= 1'b1;
                        end
                    end
                    if (commit_reg) begin
                        out_digit_reg <= shadow_digit_reg;
                        out_err_reg   <= shadow_err_reg;
                    end
                end
            end

            assign out_digit[gi]   = out_digit_reg;
            assign seg_err_vec[gi] = out_err_reg;

`ifdef BLINK_DETECT_EN
            logic shadow_blank_reg;
            logic out_blank_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shadow_blank_reg <= 1'b0;
                    out_blank_reg    <= 1'b0;
                end else begin
                    if (write_strobe && slot_hit && dec_valid) begin
                        shadow_blank_reg <= 1'b0;
                    end else if (write_blank && slot_hit) begin
                        shadow_blank_reg <= 1'b1;
                    end
                    if (commit_reg) begin
                        out_blank_reg <= shadow_blank_reg;
                    end
                end
            end

            assign blank_vec[gi] = out_blank_reg;
`else
            assign blank_vec[gi] = 1'b0;
`endif
        end
    endgenerate

`ifndef BLINK_DETECT_EN
    logic unused_write_blank;
    assign unused_write_blank = write_blank;
`endif

    assign bus.digit0     = out_digit[0];
    assign bus.digit1     = out_digit[1];
    assign bus.digit2     = out_digit[2];
    assign bus.digit3     = out_digit[3];
    assign bus.seg_err    = seg_err_vec;
    assign bus.blank_mask = blank_vec;
    assign bus.frame_done = frame_done_reg;
    assign bus.sync_err   = sync_err_reg;
    assign bus.locked     = locked_reg;

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the stopwatch's four-digit multiplexed seven-segment driver. It samples the scanned anode strobes (`AN`) and segment bus (`seg`) and decodes each strobed pattern back to a BCD digit. Each scan frame is reassembled into four stable digit outputs with per-frame error and blanking status. It sits on the board-test and loopback path: it observes the driver's outputs and feeds the verification/self-check logic, and it never drives the display.

## Interface
- `INPUT_REG`, default 1: 1 registers `AN`/`seg` before decode (+1 cycle latency); 0 decodes directly.
- `clk`  in  1  system clock; the same clock that scans the driver.
- `rst`  in  1  asynchronous, active-high reset.
- `AN`  in  4  anode strobes, active-low. `0111`=digit0, `1011`=digit1, `1101`=digit2, `1110`=digit3, `1111`=blank slot.
- `seg`  in  8  segments, active-low; bit7=dp, bits6..0 = g..a.
- `digit0`..`digit3`  out  4 each  last completed frame's decoded digits.
- `frame_done`  out  1  one-cycle pulse when the digit outputs update.
- `seg_err`  out  4  per-digit flag: an unknown pattern was strobed in the completed frame.
- `sync_err`  out  1  one-cycle pulse: strobe index ≠ expected phase, or multi-hot `AN`.
- `locked`  out  1  high after the first digit0 strobe is seen; cleared only by reset.
- `blank_mask`  out  4  per-digit flag: slot was blank in the completed frame. Tied to 0 unless `BLINK_DETECT_EN`.

## Operation
- Decode table, exact 8-bit match: C0→0, F9→1, A4→2, B0→3, 99→4, 92→5, 82→6, D8→7, 80→8, 90→9.
  - D8 (segments a,b,c,f) is the codebase's glyph for 7.
  - Any other value is an error. Each value is compared as a full byte, including dp.
- Phase counter (2-bit), one slot per cycle:
  - Unlocked: phase is ignored. A digit0 strobe sets `locked` and loads phase to 1.
  - Locked, valid one-hot strobe with index k: if k == phase, phase ← phase+1 (mod 4). If k ≠ phase, pulse `sync_err` and load phase ← k+1 (resync).
  - Locked, `AN`=1111: phase ← phase+1. Slot k=phase is treated as blank.
  - Multi-hot `AN` (two or more bits low): pulse `sync_err`, no shadow write, phase ← phase+1.
- Shadow registers (4×4 digit, 4 err, 4 blank), written per slot:
  - Valid pattern: digit[k] ← value, err[k] ← 0, blank[k] ← 0.
  - Invalid pattern: digit[k] holds its previous value, err[k] ← 1.
  - Blank slot: digit[k] holds, blank[k] ← 1.
- Frame commit: when the slot at phase 3 is processed while locked, copy the shadow to `digit*`, `seg_err` and `blank_mask`, and pulse `frame_done`.
  - Outputs are stable between commits.
  - Nothing commits before `locked` is set.
- Strobes seen while unlocked, other than the locking digit0 strobe, do not write the shadow.

## Timing
- Reset (async assert, sync release): `digit0`..`digit3`=0, `frame_done`=0, `seg_err`=0, `sync_err`=0, `locked`=0, `blank_mask`=0, phase=0, shadow=0.
- Input stage: `AN`/`seg` captured at edge E (`INPUT_REG`=1); decoded and shadow written at edge E+1.
- Commit latency: the phase-3 strobe is driven in cycle T. Then `frame_done` and the outputs update at edge T+3 (`INPUT_REG`=1), or T+2 (`INPUT_REG`=0).
  - The value committed for slot 3 is the one decoded in that same frame.
- `sync_err` is registered and aligned with the shadow-write edge.
- Reset mid-frame: the partial frame is discarded, `locked` is cleared, and re-acquisition restarts on the next digit0 strobe.
- Sustained blanking: frames still commit every 4 cycles, with `blank_mask` set for blanked slots.

## Configuration
- `BLINK_DETECT_EN` defined: blank slots set shadow blank bits and `blank_mask` reports them per frame. This is used to check the adjust-mode blink of the minutes pair (digits 0–1) or seconds pair (digits 2–3).
- Not defined: blank slots only advance phase, `blank_mask` is constant 0, and the blank shadow registers are not built.

## Structure
- Shared package `seg_scan_pkg`:
  - `AN_DIG0`..`AN_DIG3` and `AN_BLANK` constants.
  - `SEG_0`..`SEG_9` pattern constants.
  - Typedef `bcd_t` (4-bit).
- One sub-module: `seg_pattern_decode`. It is a pure combinational byte→{valid, bcd} lookup, instantiated once.
- The top module holds the input stage, phase/lock FSM, shadow and commit registers.

## Test plan
- Reset, then a driver model scans 1,2,3,4 on `AN` 0111/1011/1101/1110 repeatedly → `locked` rises; after the first full frame `frame_done` pulses and digit0..3 = 1,2,3,4; `frame_done` then pulses every 4 cycles.
- Scan with digit2 `seg`=FF (unknown) → `seg_err`=0100 on that commit, digit2 holds its previous value; the next clean frame clears `seg_err`.
- Locked, inject `AN`=1011 where phase expects digit2 → `sync_err` pulses once; phase resyncs; the next frame commits correctly.
- `AN`=0011 (multi-hot) for one cycle → `sync_err` pulse, no digit changes.
- `BLINK_DETECT_EN`, digits 0–1 blanked (`AN`=1111 in slots 0,1) → `blank_mask`=0011, digit0/1 hold 1/2. Without the macro → `blank_mask`=0.
- Assert `rst` mid-frame → all outputs 0 immediately; re-lock on the next digit0 strobe with no commit before it.
